// File: rtl/keypad_pkg.sv
// Shared constants for the keypad display buffer: key width, digit count and 7-segment patterns.
package keypad_pkg;

    localparam int unsigned KEY_W      = 4;
    localparam int unsigned NUM_DIGITS = 4;

    localparam logic [3:0] CTRL_ALL_OFF = 4'b1111;

    // Segment order {a,b,c,d,e,f,g,dp}, active-high
    localparam logic [7:0] SEG_0     = 8'hFC;
    localparam logic [7:0] SEG_1     = 8'h60;
    localparam logic [7:0] SEG_2     = 8'hDA;
    localparam logic [7:0] SEG_3     = 8'hF2;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'hB6;
    localparam logic [7:0] SEG_6     = 8'hBE;
    localparam logic [7:0] SEG_7     = 8'hE0;
    localparam logic [7:0] SEG_8     = 8'hFE;
    localparam logic [7:0] SEG_9     = 8'hF6;
    localparam logic [7:0] SEG_A     = 8'hEE;
    localparam logic [7:0] SEG_B     = 8'h3E;
    localparam logic [7:0] SEG_C     = 8'h9C;
    localparam logic [7:0] SEG_D     = 8'h7A;
    localparam logic [7:0] SEG_E     = 8'h9E;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_BLANK = 8'h00;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex digit to 7-segment pattern decoder.
module hex_to_seg
    import keypad_pkg::*;
(
    input  logic [KEY_W-1:0] hex,
    output logic [7:0]       seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/keypad_display_buffer.sv
// Stores the last four keypad codes and drives a multiplexed 4-digit 7-segment display.
module keypad_display_buffer
    import keypad_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 4000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [KEY_W-1:0] key_code,
    output logic             key_ready,
    input  logic             clear,
    output logic [2:0]       digit_count,
    output logic [3:0]       ctrl,
    output logic [7:0]       segment
);

    localparam int unsigned DivW = $clog2(REFRESH_DIV);
    localparam logic [DivW-1:0] DivLast = DivW'(REFRESH_DIV - 1);
    localparam logic [2:0] CountMax = 3'(NUM_DIGITS);

    logic [NUM_DIGITS*KEY_W-1:0] digits_q, digits_d;
    logic [2:0]                  count_q, count_d;
    logic                        ready_q, ready_d;
    logic [DivW-1:0]             div_q, div_d;
    logic [1:0]                  idx_q, idx_d;
    logic [3:0]                  ctrl_q, ctrl_d;
    logic [7:0]                  seg_q, seg_d;

    logic             accept;
    logic [KEY_W-1:0] cur_digit;
    logic [7:0]       cur_seg;

    assign accept    = key_valid & ready_q & ~clear;
    assign cur_digit = digits_q[{idx_q, 2'b00} +: KEY_W];

    hex_to_seg u_hex_to_seg (
        .hex (cur_digit),
        .seg (cur_seg)
    );

    always_comb begin
        digits_d = digits_q;
        count_d  = count_q;
        if (clear) begin
            digits_d = '0;
            count_d  = '0;
        end else if (accept) begin
            digits_d = {digits_q[(NUM_DIGITS-1)*KEY_W-1:0], key_code};
            if (count_q != CountMax) begin
                count_d = count_q + 3'd1;
            end
        end
        // One dead cycle after every accept or clear throttles the producer
        ready_d = ~(accept | clear);
    end

    always_comb begin
        div_d = div_q + 1'b1;
        idx_d = idx_q;
        if (div_q == DivLast) begin
            div_d = '0;
            idx_d = idx_q + 2'd1;
        end
        ctrl_d = ~(4'b0001 << idx_q);
        seg_d  = ({1'b0, idx_q} < count_q) ? cur_seg : SEG_BLANK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digits_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            div_q    <= '0;
            idx_q    <= '0;
            ctrl_q   <= CTRL_ALL_OFF;
            seg_q    <= SEG_BLANK;
        end else begin
            digits_q <= digits_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            div_q    <= div_d;
            idx_q    <= idx_d;
            ctrl_q   <= ctrl_d;
            seg_q    <= seg_d;
        end
    end

    assign key_ready   = ready_q;
    assign digit_count = count_q;
    assign ctrl        = ctrl_q;
    assign segment     = seg_q;

endmodule

// File: tb/tb_keypad_display_buffer.sv
// Directed self-checking bench for keypad_display_buffer with a 4-cycle refresh divider.
module tb_keypad_display_buffer;

    localparam int unsigned RefreshDiv = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       key_ready;
    logic       clear = 1'b0;
    logic [2:0] digit_count;
    logic [3:0] ctrl;
    logic [7:0] segment;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    keypad_display_buffer #(
        .REFRESH_DIV (RefreshDiv)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ready   (key_ready),
        .clear       (clear),
        .digit_count (digit_count),
        .ctrl        (ctrl),
        .segment     (segment)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_key(input logic [3:0] k);
        bit done = 1'b0;
        key_valid = 1'b1;
        key_code  = k;
        for (int i = 0; i < 10 && !done; i++) begin
            if (key_ready) done = 1'b1;
            tick();
        end
        key_valid = 1'b0;
        if (!done) check_eq("send_key_timeout", 32'(k), 32'hdead);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
    endtask

    // Compares segment against the expected pattern for whichever digit is enabled
    task automatic scan_check(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] exp_seg [4];
        bit [3:0] seen = '0;
        exp_seg[0] = e0;
        exp_seg[1] = e1;
        exp_seg[2] = e2;
        exp_seg[3] = e3;
        tick();
        tick();
        for (int c = 0; c < 5 * RefreshDiv; c++) begin
            for (int d = 0; d < 4; d++) begin
                if (ctrl == ~(4'b0001 << d)) begin
                    check_eq($sformatf("%s_d%0d", tag, d), 32'(segment), 32'(exp_seg[d]));
                    seen[d] = 1'b1;
                end
            end
            tick();
        end
        check_eq({tag, "_all_digits_seen"}, 32'(seen), 32'hf);
    endtask

    // Per-cycle checks: ctrl shape, dp off, and digit dwell time
    bit       mon_en = 1'b0;
    logic [3:0] prev_ctrl = 4'hf;
    int       run_len = 0;
    bit       run_dirty = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("ctrl_shape", 32'(ctrl inside {4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111}),
                     32'd1);
            check_eq("dp_off", 32'(segment[0]), 32'd0);
            if (ctrl == prev_ctrl) begin
                run_len++;
            end else begin
                if (prev_ctrl != 4'hf && !run_dirty) begin
                    check_eq("dwell", 32'(run_len), 32'(RefreshDiv));
                end
                run_len   = 1;
                run_dirty = 1'b0;
                prev_ctrl = ctrl;
            end
            if (rst) run_dirty = 1'b1;
        end
    end

    initial begin
        bit hit;

        // 1. reset
        repeat (3) tick();
        mon_en = 1'b1;
        check_eq("rst_ctrl", 32'(ctrl), 32'hf);
        check_eq("rst_segment", 32'(segment), 32'h00);
        check_eq("rst_ready", 32'(key_ready), 32'd0);
        check_eq("rst_count", 32'(digit_count), 32'd0);
        rst = 1'b0;
        tick();
        check_eq("ready_after_rst", 32'(key_ready), 32'd1);

        // 2. three keys
        send_key(4'h1);
        send_key(4'h2);
        send_key(4'h3);
        check_eq("count_3", 32'(digit_count), 32'd3);
        scan_check("keys123", 8'hF2, 8'hDA, 8'h60, 8'h00);

        // 3. five keys, oldest dropped
        pulse_clear();
        for (int k = 1; k <= 5; k++) send_key(4'(k));
        check_eq("count_sat", 32'(digit_count), 32'd4);
        scan_check("keys12345", 8'hB6, 8'h66, 8'hF2, 8'hDA);

        // 4. valid held six cycles
        pulse_clear();
        key_valid = 1'b1;
        key_code  = 4'h8;
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("ready_toggle_%0d", i), 32'(key_ready), 32'(i % 2 == 0));
            tick();
        end
        key_valid = 1'b0;
        check_eq("held_accepts", 32'(digit_count), 32'd3);
        scan_check("held8", 8'hFE, 8'hFE, 8'hFE, 8'h00);

        // 5. clear collides with a key
        pulse_clear();
        send_key(4'h6);
        send_key(4'h7);
        tick();
        check_eq("ready_before_clash", 32'(key_ready), 32'd1);
        clear     = 1'b1;
        key_valid = 1'b1;
        key_code  = 4'h9;
        tick();
        clear     = 1'b0;
        key_valid = 1'b0;
        check_eq("clash_ready", 32'(key_ready), 32'd0);
        check_eq("clash_count", 32'(digit_count), 32'd0);
        tick();
        check_eq("clash_ready_back", 32'(key_ready), 32'd1);
        check_eq("clash_count_hold", 32'(digit_count), 32'd0);
        scan_check("clash", 8'h00, 8'h00, 8'h00, 8'h00);

        // remaining decode entries
        send_key(4'h0);
        send_key(4'h9);
        send_key(4'hE);
        send_key(4'hF);
        scan_check("dec09EF", 8'h8E, 8'h9E, 8'hF6, 8'hFC);

        // 6. reset mid-scan with four digits stored
        pulse_clear();
        send_key(4'hA);
        send_key(4'hB);
        send_key(4'hC);
        send_key(4'hD);
        scan_check("decABCD", 8'h7A, 8'h9C, 8'h3E, 8'hEE);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (ctrl == 4'b1011) hit = 1'b1;
            else tick();
        end
        check_eq("wait_digit2", 32'(hit), 32'd1);
        check_eq("pre_rst_count", 32'(digit_count), 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_ctrl", 32'(ctrl), 32'hf);
        check_eq("midrst_count", 32'(digit_count), 32'd0);
        check_eq("midrst_ready", 32'(key_ready), 32'd0);
        check_eq("midrst_segment", 32'(segment), 32'h00);
        tick();
        check_eq("restart_ctrl", 32'(ctrl), 32'he);
        check_eq("restart_segment", 32'(segment), 32'h00);
        check_eq("restart_ready", 32'(key_ready), 32'd1);
        repeat (2 * RefreshDiv) tick();

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
